// File: rtl/unidade_busca_pkg.sv
// Shared definitions for the fetch unit and its neighbours (PC and decode).
// The state type is exported so other blocks can observe fetch progress.
package unidade_busca_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam logic [31:0] RESET_ADDR_DEF = 32'h0000_0000;
  localparam int INST_BYTES = 4;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } estado_busca_t;

endpackage

// File: rtl/unidade_busca_if.sv
// Instruction memory read channel: request (valid/ready/addr) and in-order response.
// The fetch unit uses the master view; the memory side uses the slave view.
interface unidade_busca_if
  import unidade_busca_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    input  mem_req_ready,
    input  mem_resp_valid,
    input  mem_resp_data
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_req_ready,
    output mem_resp_valid,
    output mem_resp_data
  );

endinterface

// File: rtl/unidade_busca_fila_instrucoes.sv
// Small synchronous FIFO holding {pc, instruction} pairs for decode.
// Flush wins over push and pop; a push into a full queue is accepted only
// when a pop frees the head in the same cycle. DEPTH must be a power of 2.
module fila_instrucoes #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign rd_data = storage[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the queue in one edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Entry storage; contents need no reset since occupancy gates visibility
  always_ff @(posedge clock) begin
    if (do_push) storage[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/unidade_busca.sv
// Instruction fetch unit: issues one word read at a time, queues the
// {pc, instruction} results for decode, and restarts on branch redirects.
// A queue slot is reserved before a request goes out, so a response can
// always be pushed without backpressure on the memory side.
module unidade_busca
  import unidade_busca_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_ADDR_DEF)
) (
  input  logic                clock,
  input  logic                reset,
  unidade_busca_if.master     mem,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [DATA_W-1:0]   inst_data,
  output logic [ADDR_W-1:0]   inst_pc,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_addr,
  output logic                busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  estado_busca_t            state;
  logic [ADDR_W-1:0]        fetch_pc;
  logic [ADDR_W-1:0]        req_pc;
  logic [ADDR_W-1:0]        redirect_pc;
  logic                     req_valid_q;
  logic                     accept;
  logic                     push;
  logic                     pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     slot_free_next;
  logic [CNT_W-1:0]         count;
  logic [CNT_W-1:0]         count_next;
  logic [ADDR_W+DATA_W-1:0] fifo_rd;

  assign redirect_pc = redirect_addr & ~ADDR_W'(INST_BYTES - 1);
  assign accept      = (state == ISSUE) && req_valid_q && mem.mem_req_ready;
  assign pop         = !fifo_empty && inst_ready;
  assign push        = (state == WAIT) && mem.mem_resp_valid && !redirect_valid &&
                       (!fifo_full || pop);

  assign mem.mem_req_valid = req_valid_q;
  assign mem.mem_req_addr  = fetch_pc;

  assign inst_valid           = !fifo_empty;
  assign {inst_pc, inst_data} = fifo_rd;
  assign busy                 = (state != ISSUE) || !fifo_empty;

  // Queue occupancy after this edge, used to decide whether a slot is free next cycle
  always_comb begin
    count_next = count;
    if (redirect_valid) begin
      count_next = '0;
    end else begin
      if (push) count_next = count_next + CNT_W'(1);
      if (pop)  count_next = count_next - CNT_W'(1);
    end
    slot_free_next = (count_next < CNT_W'(FIFO_DEPTH));
  end

  // Fetch FSM with registered request; redirect overrides everything else
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ISSUE;
      fetch_pc    <= RESET_ADDR;
      req_pc      <= RESET_ADDR;
      req_valid_q <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      if (accept || ((state != ISSUE) && !mem.mem_resp_valid)) begin
        state       <= DROP;
        req_valid_q <= 1'b0;
      end else begin
        state       <= ISSUE;
        req_valid_q <= 1'b1;
      end
    end else begin
      case (state)
        ISSUE: begin
          if (accept) begin
            state       <= WAIT;
            req_pc      <= fetch_pc;
            fetch_pc    <= fetch_pc + ADDR_W'(INST_BYTES);
            req_valid_q <= 1'b0;
          end else begin
            req_valid_q <= slot_free_next;
          end
        end
        WAIT, DROP: begin
          if (mem.mem_resp_valid) begin
            state       <= ISSUE;
            req_valid_q <= slot_free_next;
          end
        end
        default: begin
          state       <= ISSUE;
          req_valid_q <= 1'b0;
        end
      endcase
    end
  end

  fila_instrucoes #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fila (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .flush   (redirect_valid),
    .wr_data ({req_pc, mem.mem_resp_data}),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

endmodule
